load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_pkg.sv | 30 +++
 rtl/load_alignment.sv | 37 +++
 rtl/load_unit.sv | 111 +++++++++++
 tb/tb_load_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared load-op encodings and helpers for the load unit.
// Encodings follow the RISC-V funct3 values for loads.
package load_unit_pkg;

  localparam int LOAD_OP_WIDTH = 3;

  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'b000;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'b001;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'b010;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'b100;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'b101;

  function automatic logic op_legal(input logic [LOAD_OP_WIDTH-1:0] op);
    return (op == LOAD_OP_LB) || (op == LOAD_OP_LH) ||
           (op == LOAD_OP_LW) || (op == LOAD_OP_LBU) ||
           (op == LOAD_OP_LHU);
  endfunction

  function automatic logic op_misaligned(
    input logic [LOAD_OP_WIDTH-1:0] op,
    input logic [1:0]               lo
  );
    logic mis;
    mis = 1'b0;
    if (op == LOAD_OP_LH || op == LOAD_OP_LHU) mis = lo[0];
    if (op == LOAD_OP_LW) mis = (lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_alignment.sv
// Selects the addressed byte/halfword from a memory word and
// sign- or zero-extends it to 32 bits.
module load_alignment
  import load_unit_pkg::*;
(
  input  logic [1:0]               addr,
  input  logic [LOAD_OP_WIDTH-1:0] LOADop,
  input  logic [31:0]              word,
  output logic [31:0]              data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick byte and halfword lanes, then extend by op type
  always_comb begin
    byte_sel = word[7:0];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    data     = '0;
    unique case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    unique case (LOADop)
      LOAD_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_LBU: data = {24'h0, byte_sel};
      LOAD_OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_LHU: data = {16'h0, half_sel};
      LOAD_OP_LW:  data = word;
      default:     data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: issues one word read, waits for
// mem_ready with a timeout, and returns aligned/extended data.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              addr,
  input  logic [LOAD_OP_WIDTH-1:0] LOADop,
  output logic                     busy,
  output logic                     mem_valid,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic                     done,
  output logic [31:0]              result,
  output logic                     misaligned,
  output logic                     access_fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [31:0]              addr_q;
  logic [LOAD_OP_WIDTH-1:0] op_q;
  logic [CW-1:0]            cnt;
  logic [31:0]              aligned;
  logic                     bad_align;
  logic                     legal;
  logic                     timeout;

  assign legal     = op_legal(LOADop);
  assign bad_align = op_misaligned(LOADop, addr[1:0]);
  assign timeout   = (cnt == LAST);
  assign mem_addr  = {addr_q[31:2], 2'b00};

  load_alignment u_align (
    .addr   (addr_q[1:0]),
    .LOADop (op_q),
    .word   (mem_rdata),
    .data   (aligned)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: illegal/misaligned requests skip the memory phase
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (!legal || bad_align) state_nxt = S_DONE;
          else                     state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready || timeout) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy      = (state != S_IDLE);
    mem_valid = (state == S_REQ);
    done      = (state == S_DONE);
  end

  // Request latch, wait counter and held result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      op_q         <= '0;
      cnt          <= '0;
      result       <= '0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        addr_q       <= addr;
        op_q         <= LOADop;
        cnt          <= '0;
        result       <= '0;
        misaligned   <= legal && bad_align;
        access_fault <= 1'b0;
      end else if (state == S_REQ) begin
        if (mem_ready)    result       <= aligned;
        else if (timeout) access_fault <= 1'b1;
        else              cnt          <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected
// responses, a monitor pops and compares on every done.
module tb_load_unit;
  import load_unit_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        mis;
    logic        flt;
    int          lat;
    int          nv;
    logic [31:0] maddr;
    int          c0;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [31:0]              addr = '0;
  logic [LOAD_OP_WIDTH-1:0] LOADop = '0;
  logic                     busy;
  logic                     mem_valid;
  logic [31:0]              mem_addr;
  logic                     mem_ready = 1'b0;
  logic [31:0]              mem_rdata = '0;
  logic                     done;
  logic [31:0]              result;
  logic                     misaligned;
  logic                     access_fault;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   wait_n = 0;
  bit   never = 0;
  bit   idle_ready = 0;

  load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .addr         (addr),
    .LOADop       (LOADop),
    .busy         (busy),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .done         (done),
    .result       (result),
    .misaligned   (misaligned),
    .access_fault (access_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Memory responder: ready after wait_n stall cycles of mem_valid
  initial begin
    int vcnt;
    vcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid) begin
        mem_ready = (!never && vcnt == wait_n);
        vcnt++;
      end else begin
        vcnt = 0;
        mem_ready = idle_ready;
      end
    end
  end

  // Monitor: compares every done against the scoreboard head
  initial begin
    exp_t        e;
    int          nv_seen;
    bit          hold_ok;
    logic [31:0] hold_res;
    logic [1:0]  hold_fl;
    nv_seen = 0;
    hold_ok = 0;
    hold_res = '0;
    hold_fl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nv_seen = 0;
        hold_ok = 0;
      end else begin
        if (mem_valid) begin
          nv_seen++;
          if (q.size() > 0) chk("mem_addr", mem_addr, q[0].maddr);
        end
        if (done) begin
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got done=1 expected 0");
          end else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("misaligned", 32'(misaligned), 32'(e.mis));
            chk("access_fault", 32'(access_fault), 32'(e.flt));
            chk("latency", 32'(cyc - e.c0), 32'(e.lat));
            chk("valid_cycles", 32'(nv_seen), 32'(e.nv));
            hold_res = e.res;
            hold_fl = {e.mis, e.flt};
            hold_ok = 1;
          end
          nv_seen = 0;
        end else if (busy) begin
          hold_ok = 0;
        end else if (hold_ok) begin
          chk("hold_result", result, hold_res);
          chk("hold_flags", 32'({misaligned, access_fault}),
              32'(hold_fl));
        end
      end
    end
  end

  task automatic issue(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] rd,
    input int          w,
    input bit          nvr,
    input int          lat,
    input int          nv,
    input logic [31:0] res,
    input bit          mis,
    input bit          flt,
    input bit          push
  );
    exp_t e;
    @(posedge clk);
    #1;
    mem_rdata = rd;
    wait_n = w;
    never = nvr;
    LOADop = op;
    addr = a;
    start = 1'b1;
    e.res = res;
    e.mis = mis;
    e.flt = flt;
    e.lat = lat;
    e.nv = nv;
    e.maddr = {a[31:2], 2'b00};
    e.c0 = cyc;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'({misaligned, access_fault}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    issue(LOAD_OP_LB, 32'h1003, 32'h80FF_1234, 0, 0,
          2, 1, 32'hFFFF_FF80, 0, 0, 1);
    drain();
    // LHU with 3 stalls; a second start during REQ is ignored
    fork
      issue(LOAD_OP_LHU, 32'h2002, 32'hBEEF_0001, 3, 0,
            5, 4, 32'h0000_BEEF, 0, 0, 1);
      begin
        repeat (2) @(posedge clk);
        #2;
        start = 1'b1;
        addr = 32'h9000;
        LOADop = LOAD_OP_LW;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    join
    drain();
    issue(LOAD_OP_LW, 32'h3001, 32'h1111_1111, 0, 0,
          1, 0, 32'h0, 1, 0, 1);
    drain();
    issue(LOAD_OP_LW, 32'h4000, 32'h2222_2222, 0, 1,
          5, 4, 32'h0, 0, 1, 1);
    drain();
    issue(LOAD_OP_LW, 32'h4000, 32'hCAFE_F00D, 3, 0,
          5, 4, 32'hCAFE_F00D, 0, 0, 1);
    drain();
    issue(LOAD_OP_LH, 32'h5002, 32'h8001_7FFF, 0, 0,
          2, 1, 32'hFFFF_8001, 0, 0, 1);
    drain();
    // mem_ready while idle must not produce any response
    @(posedge clk);
    #1 idle_ready = 1;
    repeat (4) @(posedge clk);
    #1 idle_ready = 0;
    issue(LOAD_OP_LBU, 32'h6001, 32'h1234_A5FF, 1, 0,
          3, 2, 32'h0000_00A5, 0, 0, 1);
    drain();
    issue(LOAD_OP_LH, 32'h5001, 32'h3333_3333, 0, 0,
          1, 0, 32'h0, 1, 0, 1);
    drain();
    issue(LOAD_OP_LB, 32'h7002, 32'h0070_0000, 0, 0,
          2, 1, 32'h0000_0070, 0, 0, 1);
    drain();
    issue(3'b011, 32'h8000, 32'h4444_4444, 0, 0,
          1, 0, 32'h0, 0, 0, 1);
    drain();

    // Reset in the middle of a request
    issue(LOAD_OP_LW, 32'h10, 32'h5555_5555, 0, 1,
          0, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    issue(LOAD_OP_LW, 32'h0, 32'h1234_5678, 0, 0,
          2, 1, 32'h1234_5678, 0, 0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
